// File: rtl/issue_credit_ctrl.sv
// issue_credit_ctrl: credit-gated issue between fetcher and dispatcher tracking ROB/RS/LSB free entries.
// Optional perf_issued/perf_stall counters are enabled by defining ISSUE_PERF_CNT_EN.
module issue_credit_ctrl #(
    parameter int ROB_SIZE     = 16,
    parameter int RS_SIZE      = 16,
    parameter int LSB_SIZE     = 16,
    parameter int CNT_W        = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic [CNT_W-1:0] lsb_keep,
    input  logic             if_valid,
    input  logic [6:0]       if_opcode,
    input  logic             rob_release,
    input  logic             rs_release,
    input  logic             lsb_release,
    output logic             issue_grant,
    output logic             issue_to_lsb,
    output logic [1:0]       stall_reason,
    output logic [1:0]       ctrl_state
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [CNT_W:0] ROB_LIM = (CNT_W+1)'(ROB_SIZE);
    localparam logic [CNT_W:0] RS_LIM  = (CNT_W+1)'(RS_SIZE);
    localparam logic [CNT_W:0] LSB_LIM = (CNT_W+1)'(LSB_SIZE);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0] rob_free, rs_free, lsb_free, lsb_reload;
    logic [2:0] flush_cnt;
    logic [1:0] reason;
    logic is_ls;

    // Releases above the structure size saturate so a spurious release cannot mint credit.
    function automatic logic [CNT_W-1:0] upd(input logic [CNT_W-1:0] f, input logic r, input logic t,
                                            input logic [CNT_W:0] lim);
        logic [CNT_W:0] s;
        s = {1'b0, f} + {{CNT_W{1'b0}}, r} - {{CNT_W{1'b0}}, t};
        return s > lim ? lim[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction

    always_comb begin
        is_ls = if_opcode == 7'b0000011 || if_opcode == 7'b0100011;
        issue_grant = rdy & ~rst & ~rollback & (ctrl_state != FLUSH) & if_valid & (rob_free != '0)
                      & (is_ls ? lsb_free != '0 : rs_free != '0);
        issue_to_lsb = issue_grant & is_ls;
        reason = rob_free == '0 ? 2'd1 : is_ls ? (lsb_free == '0 ? 2'd3 : 2'd0) : (rs_free == '0 ? 2'd2 : 2'd0);
        lsb_reload = {1'b0, lsb_keep} > LSB_LIM ? '0 : CNT_W'(LSB_LIM - {1'b0, lsb_keep});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_free     <= ROB_LIM[CNT_W-1:0];
            rs_free      <= RS_LIM[CNT_W-1:0];
            lsb_free     <= LSB_LIM[CNT_W-1:0];
            ctrl_state   <= RUN;
            stall_reason <= 2'd0;
            flush_cnt    <= 3'd0;
        end else if (rdy) begin
            if (rollback) begin
                rob_free     <= ROB_LIM[CNT_W-1:0];
                rs_free      <= RS_LIM[CNT_W-1:0];
                lsb_free     <= lsb_reload;
                ctrl_state   <= FLUSH;
                stall_reason <= 2'd0;
                flush_cnt    <= FL_INIT;
            end else begin
                rob_free     <= upd(rob_free, rob_release, issue_grant, ROB_LIM);
                rs_free      <= upd(rs_free, rs_release, issue_grant & ~is_ls, RS_LIM);
                lsb_free     <= upd(lsb_free, lsb_release, issue_to_lsb, LSB_LIM);
                stall_reason <= (ctrl_state != FLUSH && if_valid && !issue_grant) ? reason : 2'd0;
                if (ctrl_state == FLUSH) begin
                    flush_cnt  <= flush_cnt == 3'd0 ? 3'd0 : flush_cnt - 3'd1;
                    ctrl_state <= flush_cnt == 3'd0 ? RUN : FLUSH;
                end else begin
                    ctrl_state <= (if_valid & ~issue_grant) ? STALL : RUN;
                end
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= 32'd0;
            perf_stall  <= 32'd0;
        end else if (rdy) begin
            perf_issued <= perf_issued + {31'd0, issue_grant};
            perf_stall  <= perf_stall + {31'd0, ctrl_state == STALL};
        end
    end
`endif
endmodule

// File: tb/tb_issue_credit_ctrl.sv
// tb_issue_credit_ctrl: directed scenarios plus random traffic checked every cycle against a credit model.
module tb_issue_credit_ctrl;
    localparam int ROB = 16, RS = 16, LSB = 16, CW = 5, FC = 2;
    localparam logic [6:0] ALU = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;

    logic clk = 0, rst = 1, rdy = 0, rollback = 0, if_valid = 0;
    logic rob_release = 0, rs_release = 0, lsb_release = 0;
    logic [CW-1:0] lsb_keep = '0;
    logic [6:0] if_opcode = '0;
    logic issue_grant, issue_to_lsb;
    logic [1:0] stall_reason, ctrl_state;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int checks = 0, errors = 0, n_grant = 0;
    int m_rob = ROB, m_rs = RS, m_lsb = LSB, flush_left = 0, m_reason = 0;
    bit stalled = 0, chk_en = 0;
    logic [31:0] p_iss = 0, p_stl = 0;

    issue_credit_ctrl #(.ROB_SIZE(ROB), .RS_SIZE(RS), .LSB_SIZE(LSB), .CNT_W(CW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .lsb_keep(lsb_keep),
        .if_valid(if_valid), .if_opcode(if_opcode), .rob_release(rob_release),
        .rs_release(rs_release), .lsb_release(lsb_release), .issue_grant(issue_grant),
        .issue_to_lsb(issue_to_lsb), .stall_reason(stall_reason), .ctrl_state(ctrl_state)
`ifdef ISSUE_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ls(input logic [6:0] op);
        return op == LD || op == ST;
    endfunction

    function automatic bit exp_grant();
        return rdy && !rst && !rollback && flush_left == 0 && if_valid && m_rob > 0
               && (is_ls(if_opcode) ? m_lsb > 0 : m_rs > 0);
    endfunction

    function automatic int exp_state();
        return flush_left > 0 ? 2 : stalled ? 1 : 0;
    endfunction

    // Free-entry counts as plain integers; FLUSH is "blocked cycles still owed".
    task automatic model_step();
        bit g = exp_grant();
        bit ls = is_ls(if_opcode);
        if (rst) begin
            m_rob = ROB; m_rs = RS; m_lsb = LSB;
            flush_left = 0; stalled = 0; m_reason = 0; p_iss = 0; p_stl = 0;
        end else if (rdy) begin
            p_iss += 32'(g);
            p_stl += 32'(exp_state() == 1);
            if (rollback) begin
                m_rob = ROB; m_rs = RS;
                m_lsb = int'(lsb_keep) > LSB ? 0 : LSB - int'(lsb_keep);
                flush_left = FC; stalled = 0; m_reason = 0;
            end else begin
                if (if_valid && !g && flush_left == 0)
                    m_reason = m_rob == 0 ? 1 : ls ? (m_lsb == 0 ? 3 : 0) : (m_rs == 0 ? 2 : 0);
                else
                    m_reason = 0;
                m_rob = m_rob + int'(rob_release) - int'(g);
                m_rs  = m_rs + int'(rs_release) - int'(g && !ls);
                m_lsb = m_lsb + int'(lsb_release) - int'(g && ls);
                if (m_rob > ROB) m_rob = ROB;
                if (m_rs > RS) m_rs = RS;
                if (m_lsb > LSB) m_lsb = LSB;
                if (flush_left > 0) begin
                    flush_left--;
                    stalled = 0;
                end else begin
                    stalled = if_valid && !g;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; rdy = 0; rollback = 0; if_valid = 0; lsb_keep = '0;
        rob_release = 0; rs_release = 0; lsb_release = 0; if_opcode = ALU;
        tick();
        rst = 0; rdy = 1;
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("grant", 32'(issue_grant), 32'(exp_grant()));
            chk("to_lsb", 32'(issue_to_lsb), 32'(exp_grant() && is_ls(if_opcode)));
            chk("stall_reason", 32'(stall_reason), 32'(m_reason));
            chk("ctrl_state", 32'(ctrl_state), 32'(exp_state()));
`ifdef ISSUE_PERF_CNT_EN
            chk("perf_issued", perf_issued, p_iss);
            chk("perf_stall", perf_stall, p_stl);
`endif
            if (issue_grant) n_grant++;
        end
    end

    initial begin
        tick();
        chk_en = 1;
        // 1: ALU stream with no releases drains ROB and RS together
        do_reset();
        chk("rst_state", 32'(ctrl_state), 0);
        chk("rst_reason", 32'(stall_reason), 0);
        if_valid = 1; n_grant = 0;
        repeat (20) tick();
        chk("t1_grants", n_grant, 16);
        chk("t1_state", 32'(ctrl_state), 1);
        chk("t1_reason", 32'(stall_reason), 1);
        // 1b: ROB kept topped up, RS alone runs out
        do_reset();
        if_valid = 1; rob_release = 1; n_grant = 0;
        repeat (20) tick();
        chk("t1b_grants", n_grant, 16);
        chk("t1b_reason", 32'(stall_reason), 2);
        // 2: alternating load/ALU with RS/LSB releases, ROB limits
        do_reset();
        if_valid = 1; rs_release = 1; lsb_release = 1; n_grant = 0;
        for (int i = 0; i < 20; i++) begin
            if_opcode = i[0] ? ALU : LD;
            tick();
        end
        chk("t2_grants", n_grant, 16);
        chk("t2_reason", 32'(stall_reason), 1);
        // 3: ROB full, release and request overlap
        if_opcode = ALU; rob_release = 1; n_grant = 0;
        repeat (4) tick();
        rob_release = 0;
        repeat (2) tick();
        chk("t3_grants", n_grant, 4);
        chk("t3_state", 32'(ctrl_state), 1);
        // 4: rollback while stalled, three committed stores survive
        rs_release = 0; lsb_release = 0;
        rollback = 1; lsb_keep = 5'd3; if_opcode = LD; n_grant = 0;
        tick();
        rollback = 0; lsb_keep = '0;
        chk("t4_state_flush", 32'(ctrl_state), 2);
        repeat (2) tick();
        chk("t4_flush_grants", n_grant, 0);
        n_grant = 0;
        repeat (16) tick();
        chk("t4_load_grants", n_grant, 13);
        chk("t4_reason", 32'(stall_reason), 3);
        // 5: rdy low mid-stream ignores releases
        do_reset();
        if_valid = 1; if_opcode = ALU;
        repeat (3) tick();
        rdy = 0; rob_release = 1; rs_release = 1; lsb_release = 1; n_grant = 0;
        repeat (5) tick();
        chk("t5_frozen_grants", n_grant, 0);
        chk("t5_state", 32'(ctrl_state), 0);
        chk("t5_reason", 32'(stall_reason), 0);
        rdy = 1; rob_release = 0; rs_release = 0; lsb_release = 0; n_grant = 0;
        repeat (16) tick();
        chk("t5_after_grants", n_grant, 13);
`ifdef ISSUE_PERF_CNT_EN
        // 6: 10 grants then 4 STALL cycles; rollback keeps the counters
        do_reset();
        rollback = 1; lsb_keep = 5'd16;
        tick();
        rollback = 0; lsb_keep = '0;
        repeat (2) tick();
        if_valid = 1; if_opcode = ALU;
        repeat (10) tick();
        if_opcode = LD;
        repeat (4) tick();
        if_valid = 0;
        tick();
        chk("t6_issued", perf_issued, 10);
        chk("t6_stall", perf_stall, 4);
        rollback = 1;
        tick();
        rollback = 0;
        chk("t6_issued_rb", perf_issued, 10);
        chk("t6_stall_rb", perf_stall, 4);
`endif
        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            rdy = $urandom_range(0, 7) != 0;
            rollback = rdy && $urandom_range(0, 59) == 0;
            lsb_keep = CW'($urandom_range(0, LSB));
            if_valid = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 3))
                0: if_opcode = LD;
                1: if_opcode = ST;
                2: if_opcode = ALU;
                default: if_opcode = 7'($urandom);
            endcase
            rob_release = $urandom_range(0, 2) == 0;
            rs_release = $urandom_range(0, 2) == 0;
            lsb_release = $urandom_range(0, 2) == 0;
            tick();
        end
        rst = 0; rollback = 0; if_valid = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
